// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive sequencer: FSM state encoding,
// parameter defaults and the 3-sample majority vote.
package uart_pkg;

  localparam int unsigned DEF_CLKS_PER_TICK = 4;
  localparam int unsigned DEF_OVERSAMPLE    = 16;
  localparam int unsigned DEF_DATA_BITS     = 8;
  localparam int unsigned DEF_PARITY_EN     = 1;
  localparam int unsigned DEF_PARITY_ODD    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider and per-bit phase counter; both restart from zero on clear
// so sampling is aligned to the accepted start edge.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_TICK = 4,
  parameter int unsigned OVERSAMPLE    = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          enable,
  output logic                          tick,
  output logic [$clog2(OVERSAMPLE)-1:0] phase,
  output logic                          bit_end
);

  localparam int unsigned DIV_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
  localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_TICK - 1);
  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(OVERSAMPLE - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick    = enable && (div_cnt == DIV_MAX);
  assign bit_end = tick && (phase == PH_MAX);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      div_cnt <= '0;
      phase   <= '0;
    end else if (enable) begin
      if (tick) begin
        div_cnt <= '0;
        phase   <= (phase == PH_MAX) ? '0 : phase + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: synchronises the line, validates the start bit, votes each bit
// and strobes the SIPO/parity/stop datapath, then reports frame status via valid/ack.
module uart_rx_sequencer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = DEF_CLKS_PER_TICK,
  parameter int unsigned OVERSAMPLE    = DEF_OVERSAMPLE,
  parameter int unsigned DATA_BITS     = DEF_DATA_BITS,
  parameter int unsigned PARITY_EN     = DEF_PARITY_EN,
  parameter int unsigned PARITY_ODD    = DEF_PARITY_ODD
) (
  input  logic clock,
  input  logic reset,
  input  logic rx_in,
  output logic sample_bit,
  output logic shift_en,
  output logic parity_en,
  output logic stop_en,
  output logic busy,
  output logic frame_valid,
  input  logic frame_ack,
  output logic parity_error,
  output logic stop_error,
  output logic overrun
);

  localparam int unsigned PH_W  = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [PH_W-1:0]  PH_LO    = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0]  PH_HI    = PH_W'(OVERSAMPLE / 2 + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             PAR_EN   = (PARITY_EN != 0);
  localparam logic             PAR_ODD  = (PARITY_ODD != 0);

  logic             rx_meta, rx_s, rx_s_d;
  logic             fall, start_hit;
  logic             tick, bit_end, strobe_pt, vote;
  logic [PH_W-1:0]  phase;
  logic [1:0]       vote_hist;
  logic [IDX_W-1:0] bit_idx;
  logic             run_par, par_err_q;
  rx_state_e        state;

  // NOTE: the synchroniser resets to the idle-line level so leaving reset never looks like a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign fall      = rx_s_d & ~rx_s;
  assign start_hit = (state == ST_IDLE) && fall;

  uart_baud_tick #(
    .CLKS_PER_TICK (CLKS_PER_TICK),
    .OVERSAMPLE    (OVERSAMPLE)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .clear   (start_hit),
    .enable  (state != ST_IDLE),
    .tick    (tick),
    .phase   (phase),
    .bit_end (bit_end)
  );

  // The third vote sample is taken live at the strobe point itself.
  assign strobe_pt = tick && (phase == PH_HI);
  assign vote      = majority3(vote_hist[1], vote_hist[0], rx_s);

  always_ff @(posedge clock) begin
    if (reset) begin
      vote_hist <= '0;
    end else if (tick && (phase == PH_LO || phase == PH_MID)) begin
      vote_hist <= {vote_hist[0], rx_s};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_idx      <= '0;
      run_par      <= 1'b0;
      par_err_q    <= 1'b0;
      sample_bit   <= 1'b0;
      shift_en     <= 1'b0;
      parity_en    <= 1'b0;
      stop_en      <= 1'b0;
      busy         <= 1'b0;
      frame_valid  <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      shift_en  <= 1'b0;
      parity_en <= 1'b0;
      stop_en   <= 1'b0;
      if (strobe_pt) sample_bit <= vote;
      if (frame_ack && frame_valid) begin
        frame_valid <= 1'b0;
        overrun     <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (strobe_pt && vote) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state     <= ST_DATA;
            bit_idx   <= '0;
            run_par   <= 1'b0;
            par_err_q <= 1'b0;
          end
        end
        ST_DATA: begin
          if (strobe_pt) begin
            shift_en <= 1'b1;
            run_par  <= run_par ^ vote;
          end
          if (bit_end) begin
            if (bit_idx == IDX_LAST) state <= PAR_EN ? ST_PARITY : ST_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end
        end
        ST_PARITY: begin
          if (strobe_pt) begin
            parity_en <= 1'b1;
            par_err_q <= vote ^ run_par ^ PAR_ODD;
          end
          if (bit_end) state <= ST_STOP;
        end
        ST_STOP: begin
          // Return to IDLE at the strobe so a start edge late in the stop bit is caught.
          if (strobe_pt) begin
            stop_en      <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
            frame_valid  <= 1'b1;
            parity_error <= par_err_q;
            stop_error   <= ~vote;
            if (frame_valid && !frame_ack) overrun <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: stimulus pushes expected strobes/status into a
// scoreboard queue, an independent monitor pops and compares on every DUT strobe.
module tb_uart_rx_sequencer;

  localparam int BIT_CLKS = 64;
  localparam int K_SHIFT  = 0;
  localparam int K_PARITY = 1;
  localparam int K_STOP   = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rx_in = 1'b1;
  logic frame_ack = 1'b0;
  logic sample_bit, shift_en, parity_en, stop_en, busy;
  logic frame_valid, parity_error, stop_error, overrun;

  typedef struct {
    int   kind;
    logic bit_v;
    logic perr;
    logic serr;
    logic ovr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   strobe_cnt = 0;

  always #5 clock = ~clock;

  uart_rx_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .rx_in        (rx_in),
    .sample_bit   (sample_bit),
    .shift_en     (shift_en),
    .parity_en    (parity_en),
    .stop_en      (stop_en),
    .busy         (busy),
    .frame_valid  (frame_valid),
    .frame_ack    (frame_ack),
    .parity_error (parity_error),
    .stop_error   (stop_error),
    .overrun      (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] all_outs();
    return {sample_bit, shift_en, parity_en, stop_en, busy,
            frame_valid, parity_error, stop_error, overrun};
  endfunction

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && (shift_en || parity_en || stop_en)) begin
        int   k;
        exp_t e;
        strobe_cnt++;
        k = shift_en ? K_SHIFT : (parity_en ? K_PARITY : K_STOP);
        if (exp_q.size() == 0) begin
          check("sb_pending", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sb_kind", k, e.kind);
          check("sb_bit", sample_bit, e.bit_v);
          if (k == K_STOP) begin
            check("sb_frame_valid", frame_valid, 1);
            check("sb_parity_error", parity_error, e.perr);
            check("sb_stop_error", stop_error, e.serr);
            check("sb_overrun", overrun, e.ovr);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    @(negedge clock) rx_in = b;
    repeat (BIT_CLKS - 1) @(negedge clock);
  endtask

  task automatic idle_bits(input int n);
    @(negedge clock) rx_in = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clock);
  endtask

  task automatic push_exp(input int kind, input logic b, input logic perr,
                          input logic serr, input logic ovr);
    exp_t e;
    e.kind = kind; e.bit_v = b; e.perr = perr; e.serr = serr; e.ovr = ovr;
    exp_q.push_back(e);
  endtask

  // exp_perr / exp_ovr are supplied by the caller from hand calculation.
  task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit,
                            input logic exp_perr, input logic exp_ovr);
    for (int i = 0; i < 8; i++) push_exp(K_SHIFT, data[i], 1'b0, 1'b0, 1'b0);
    push_exp(K_PARITY, par_bit, 1'b0, 1'b0, 1'b0);
    push_exp(K_STOP, stop_bit, exp_perr, ~stop_bit, exp_ovr);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(par_bit);
    drive_bit(stop_bit);
  endtask

  task automatic ack();
    @(negedge clock) frame_ack = 1'b1;
    @(negedge clock) frame_ack = 1'b0;
  endtask

  initial begin
    logic       saw_busy;
    int         strobes_before;
    logic [7:0] d;

    // Reset state
    repeat (4) @(negedge clock);
    check("reset_outputs", all_outs(), 9'h0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("idle_outputs", all_outs(), 9'h0);

    // 1: 0xA5, four ones -> even parity bit 0, good stop
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    check("t1_sb_empty", exp_q.size(), 0);
    check("t1_status", {frame_valid, parity_error, stop_error, overrun}, 4'b1000);
    check("t1_busy", busy, 0);
    ack();
    check("t1_ack_valid", frame_valid, 0);

    // 2: 0x01 with parity bit 0 -> one '1' total, even parity violated
    send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_bits(1);
    check("t2_sb_empty", exp_q.size(), 0);
    check("t2_status", {frame_valid, parity_error, stop_error}, 3'b110);
    ack();
    check("t2_errors_hold", {frame_valid, parity_error}, 2'b01);

    // 3: stop bit 0, then break held for 500 clocks
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    saw_busy = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (busy) saw_busy = 1'b1;
    end
    check("t3_break_no_busy", saw_busy, 0);
    check("t3_status", {frame_valid, parity_error, stop_error}, 3'b101);
    idle_bits(2);
    check("t3_sb_empty", exp_q.size(), 0);
    ack();

    // 4: 20-clock low glitch -> false start, no strobes
    strobes_before = strobe_cnt;
    saw_busy = 1'b0;
    @(negedge clock) rx_in = 1'b0;
    repeat (20) @(negedge clock);
    rx_in = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(negedge clock);
      if (busy) saw_busy = 1'b1;
    end
    check("t4_busy_rose", saw_busy, 1);
    check("t4_busy_fell", busy, 0);
    check("t4_no_strobes", strobe_cnt - strobes_before, 0);
    check("t4_no_status", frame_valid, 0);

    // 5: two frames without ack; 0x07 has three ones -> parity 0 is an error
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b1);
    idle_bits(1);
    check("t5_sb_empty", exp_q.size(), 0);
    check("t5_status", {frame_valid, parity_error, stop_error, overrun}, 4'b1101);
    ack();
    check("t5_after_ack", {frame_valid, overrun}, 2'b00);

    // 6: reset during data bit 4 of 0x5A, then a clean 0xC3 frame
    d = 8'h5A;
    for (int i = 0; i < 4; i++) push_exp(K_SHIFT, d[i], 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    @(negedge clock) rx_in = d[4];
    repeat (20) @(negedge clock);
    check("t6_busy_before_reset", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check("t6_reset_outputs", all_outs(), 9'h0);
    reset = 1'b0;
    check("t6_sb_empty_abort", exp_q.size(), 0);
    strobes_before = strobe_cnt;
    idle_bits(2);
    check("t6_no_strobes_after_reset", strobe_cnt - strobes_before, 0);
    check("t6_no_status", frame_valid, 0);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_bits(1);
    check("t6_sb_empty", exp_q.size(), 0);
    check("t6_status", {frame_valid, parity_error, stop_error, overrun}, 4'b1000);
    ack();
    check("t6_ack_valid", frame_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
